pll_freq_monitor: RTL
=====================

PLL_FREQ_MONITOR -- requirements
Module: pll_freq_monitor

Interface
- REQ-001: Parameter GATE_CYCLES, default 27000; measurement window length in clkin cycles (1 ms at 27 MHz); legal range 2..2^24-1.
- REQ-002: Parameter CNT_W, default 16; width of the edge counter and of freq_count.
- REQ-003: Parameter EXP_MIN, default 21500; lowest in-range edge count per window, inclusive.
- REQ-004: Parameter EXP_MAX, default 22400; highest in-range edge count per window, inclusive; EXP_MIN <= EXP_MAX.
- REQ-005: Parameter LOCK_COUNT, default 4; consecutive in-range windows required to declare lock; legal range 1..15.
- REQ-006: clkin  input  1  single system clock, 27 MHz board oscillator; all logic on its rising edge.
- REQ-007: reset  input  1  synchronous, active-high reset.
- REQ-008: tick_toggle  input  1  asynchronous toggle from the PLL output domain, flipped once per fixed number of PLL cycles.
- REQ-009: freq_count  output  CNT_W  edge count of the most recent completed window.
- REQ-010: meas_valid  output  1  one-cycle pulse when freq_count updates.
- REQ-011: locked  output  1  high while the FSM is in LOCKED.
- REQ-012: loss_pulse  output  1  one-cycle pulse on the LOCKED -> UNLOCKED transition.
- REQ-013: loss_count  output  8  number of lock losses since reset; saturates at 255.

Function
- REQ-014: tick_toggle SHALL pass through a 2-flop synchronizer; a third flop SHALL provide the previous value, and an edge SHALL be sync2 XOR sync3, so both polarities count.
- REQ-015: Gate counter SHALL run 0..GATE_CYCLES-1 and wrap; the cycle in which it equals GATE_CYCLES-1 is the window close.
- REQ-016: Edge counter SHALL increment by 1 per detected edge and saturate at 2^CNT_W-1 (no wrap).
- REQ-017: At window close, freq_count SHALL load the edge counter value plus any edge detected in that same cycle (saturated); the edge counter SHALL then restart at 0; meas_valid SHALL pulse in the next cycle, aligned with the new freq_count value.
- REQ-018: in_range SHALL be EXP_MIN <= closing count <= EXP_MAX, unsigned compare, evaluated once per window close.
- REQ-019: FSM states: UNLOCKED, ACQUIRE, LOCKED; 4-bit good counter.
- REQ-020: UNLOCKED: in_range with LOCK_COUNT=1 -> LOCKED; in_range otherwise -> ACQUIRE with good=1; out of range -> stay, good=0.
- REQ-021: ACQUIRE: in_range -> good+1, and go to LOCKED when good+1 = LOCK_COUNT; out of range -> UNLOCKED, good=0.
- REQ-022: LOCKED: in_range -> stay; a single out-of-range window -> UNLOCKED with good=0, loss_pulse high for one cycle, loss_count+1 (saturating).
- REQ-023: State transitions, locked, loss_pulse and loss_count SHALL update in the same cycle as meas_valid.
- REQ-024: Between window closes the FSM SHALL hold; a stalled tick_toggle yields count 0, which is out of range unless EXP_MIN = 0.

Reset
- REQ-025: While reset is high, at the next clkin edge: synchronizer flops, gate counter, edge counter, good counter and freq_count SHALL go to 0; state SHALL go to UNLOCKED; meas_valid, locked, loss_pulse and loss_count SHALL go to 0.
- REQ-026: Reset mid-window SHALL discard the partial count; the first window after release SHALL be a full GATE_CYCLES long and begin in the cycle after reset deasserts.
- REQ-027: The first sampled value of tick_toggle after reset SHALL NOT count as an edge. The sync3 flop SHALL be loaded from sync2 during the first post-reset cycle, before edge detection is enabled.

Verification (bench params: GATE_CYCLES=100, EXP_MIN=18, EXP_MAX=22, LOCK_COUNT=3, CNT_W=8)
- REQ-028: Toggle every 5 cycles -> meas_valid every 100 cycles with freq_count=20; locked rises at the 3rd meas_valid; loss_count=0.
- REQ-029: Locked, then toggle every 4 cycles (25 edges) for one window -> freq_count=25, loss_pulse once, locked=0, loss_count=1; relock after 3 further good windows.
- REQ-030: In ACQUIRE (good=2), one window at 30 edges -> UNLOCKED; 3 fresh good windows are needed to lock.
- REQ-031: Toggle every cycle for 300 windows with CNT_W=6 -> freq_count saturates at 63; out of range, never locks.
- REQ-032: Assert reset for 1 cycle at gate count 50 while locked -> all outputs 0 next cycle; next meas_valid exactly 100 cycles after release, with freq_count=20.
- REQ-033: Force 256+ lock losses -> loss_count holds at 255.

Source files
------------

// File: rtl/pll_freq_monitor.sv
// PLL frequency monitor: counts synchronized tick_toggle edges over a fixed
// clkin window and tracks lock with an UNLOCKED/ACQUIRE/LOCKED state machine.
`timescale 1ns/1ps
module pll_freq_monitor #(
    parameter int unsigned GATE_CYCLES = 27000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EXP_MIN     = 21500,
    parameter int unsigned EXP_MAX     = 22400,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             tick_toggle,
    output logic [CNT_W-1:0] freq_count,
    output logic             meas_valid,
    output logic             locked,
    output logic             loss_pulse,
    output logic [7:0]       loss_count
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [3:0]        LOCK_N    = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic [2:0]        warm;
    logic              tick_edge;
    logic [GATE_W-1:0] gate_cnt;
    logic              window_close;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_inc;
    logic [CNT_W-1:0]  closing_count;
    logic              in_range;
    state_t            state;
    state_t            state_d;
    logic [3:0]        good;
    logic [3:0]        good_d;
    logic [3:0]        good_inc;
    logic              loss_d;

    // Synchronizer plus history flop; warm keeps edges masked until sync3
    // holds a genuine post-reset sample, so the first sample never counts.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            warm  <= 3'b000;
        end else begin
            sync1 <= tick_toggle;
            sync2 <= sync1;
            sync3 <= sync2;
            warm  <= {warm[1:0], 1'b1};
        end
    end

    assign tick_edge     = warm[2] & (sync2 ^ sync3);
    assign window_close  = (gate_cnt == GATE_LAST);
    assign edge_inc      = tick_edge && (edge_cnt != CNT_MAX);
    assign closing_count = edge_inc ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign in_range      = (32'(closing_count) >= EXP_MIN) &&
                           (32'(closing_count) <= EXP_MAX);
    assign good_inc      = good + 4'd1;

    // Gate counter: free-running window timer, wraps after GATE_CYCLES.
    always_ff @(posedge clkin) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (window_close) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
        end
    end

    // Saturating edge counter, restarted at every window close.
    always_ff @(posedge clkin) begin
        if (reset) begin
            edge_cnt <= '0;
        end else if (window_close) begin
            edge_cnt <= '0;
        end else if (edge_inc) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

    // Publish the closing count with a one-cycle valid strobe.
    always_ff @(posedge clkin) begin
        if (reset) begin
            freq_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= window_close;
            if (window_close) begin
                freq_count <= closing_count;
            end
        end
    end

    // Lock FSM next-state: only evaluated at window close, holds otherwise.
    always_comb begin
        state_d = state;
        good_d  = good;
        loss_d  = 1'b0;
        if (window_close) begin
            case (state)
                UNLOCKED: begin
                    if (in_range) begin
                        good_d  = 4'd1;
                        state_d = (LOCK_N == 4'd1) ? LOCKED : ACQUIRE;
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ACQUIRE: begin
                    if (in_range) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d  = 4'd0;
                        state_d = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!in_range) begin
                        good_d  = 4'd0;
                        state_d = UNLOCKED;
                        loss_d  = 1'b1;
                    end
                end
                default: begin
                    good_d  = 4'd0;
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    // Lock FSM state register and registered status outputs.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state      <= UNLOCKED;
            good       <= 4'd0;
            locked     <= 1'b0;
            loss_pulse <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            state      <= state_d;
            good       <= good_d;
            locked     <= (state_d == LOCKED);
            loss_pulse <= loss_d;
            if (loss_d && (loss_count != 8'hFF)) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

endmodule
